// File: rtl/data_mem_responder.sv
// Data-memory responder: word SRAM behind a request/grant/response handshake
// with a fixed number of wait states, alignment/range checking and byte-lane stores.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | grant asserted, waiting for a request
// S_WAIT | request latched, counting down wait states, access at zero
// S_RESP | one-cycle response pulse with registered data/error
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_p,
  input  logic        i_req,
  output logic        o_gnt,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [3:0]  i_be,
  input  logic [31:0] i_wdata,
  output logic        o_rvalid,
  output logic [31:0] o_rdata,
  output logic        o_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t state, state_nxt;

  logic [CW-1:0] cnt;
  logic          we_q;
  logic [31:0]   addr_q;
  logic [3:0]    be_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          err_q;

  logic [31:0]   mem [DEPTH_WORDS];

  logic [29:0]   word_idx;
  logic [AW-1:0] mem_idx;
  logic          acc_err;
  logic          accept;
  logic          access;

  assign word_idx = addr_q[31:2];
  assign mem_idx  = addr_q[AW+1:2];
  assign acc_err  = (addr_q[1:0] != 2'b00) || (word_idx >= 30'(DEPTH_WORDS));
  assign accept   = (state == S_IDLE) && i_req;
  assign access   = (state == S_WAIT) && (cnt == '0);

  always_ff @(posedge i_clk or posedge i_rst_p) begin
    if (i_rst_p) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (i_req) state_nxt = S_WAIT;
      S_WAIT:  if (cnt == '0) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_gnt    = (state == S_IDLE) && !i_rst_p;
    o_rvalid = (state == S_RESP);
    o_rdata  = o_rvalid ? rdata_q : 32'h0;
    o_err    = o_rvalid ? err_q : 1'b0;
  end

  // Holding registers: only these feed the access, so input changes after accept are ignored.
  always_ff @(posedge i_clk or posedge i_rst_p) begin
    if (i_rst_p) begin
      cnt     <= '0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        cnt     <= CW'(WAIT_CYCLES);
        we_q    <= i_we;
        addr_q  <= i_addr;
        be_q    <= i_be;
        wdata_q <= i_wdata;
      end else if ((state == S_WAIT) && (cnt != '0)) begin
        cnt <= cnt - CW'(1);
      end
      if (access) begin
        err_q   <= acc_err;
        rdata_q <= (!we_q && !acc_err) ? mem[mem_idx] : 32'h0;
      end
    end
  end

  // Array is deliberately not reset; reset forces S_IDLE so no access can fire.
  always_ff @(posedge i_clk) begin
    if (access && we_q && !acc_err) begin
      for (int k = 0; k < 4; k++) begin
        if (be_q[k]) mem[mem_idx][8*k +: 8] <= wdata_q[8*k +: 8];
      end
    end
  end

endmodule
